// File: rtl/dii_worm_arbiter.sv
// Wormhole round-robin arbiter: merges N DII inputs onto one registered DII output,
// holding a granted input until its packet's last flit has transferred.
module dii_worm_arbiter #(
  parameter int N     = 2,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         grant,
  output logic                 busy
);

  // state  | meaning
  // IDLE   | no packet in flight; arbitrate among valid inputs from ptr
  // LOCKED | mid-packet; only lock_idx is served until its last flit

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] N_W = (PW+1)'(N);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     lock_idx_q, lock_idx_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  logic [PW-1:0]     sel;
  logic [PW:0]       idx;
  logic              sel_vld;
  logic              can_accept;
  logic              xfer;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    logic [PW:0] s;
    s = {1'b0, v} + {{PW{1'b0}}, 1'b1};
    if (s >= N_W) s = '0;
    return s[PW-1:0];
  endfunction

  // Rotating search: first valid input starting at ptr, wrapping mod N.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    if (state_q == LOCKED) begin
      sel     = lock_idx_q;
      sel_vld = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = {1'b0, ptr_q} + (PW+1)'(k);
        if (idx >= N_W) idx = idx - N_W;
        if (!sel_vld && in_valid[idx[PW-1:0]]) begin
          sel     = idx[PW-1:0];
          sel_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    can_accept = !out_valid_q || out_ready;
    grant      = '0;
    if (!rst && sel_vld) grant[sel] = 1'b1;
    in_ready   = can_accept ? grant : '0;
    xfer       = |(in_valid & in_ready);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_idx_d  = lock_idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (xfer) begin
      out_data_d  = in_data[sel*WIDTH +: WIDTH];
      out_last_d  = in_last[sel];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (in_last[sel]) begin
            ptr_d = wrap_inc(sel);
          end else begin
            state_d    = LOCKED;
            lock_idx_d = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer && in_last[sel]) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(lock_idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      lock_idx_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_idx_q  <= lock_idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == LOCKED) || out_valid_q;

endmodule

// File: doc/dii_worm_arbiter.md
Name: dii_worm_arbiter

Overview:
- Packet-level (wormhole) round-robin arbiter that merges N DII input channels onto one DII output channel.
- Once a packet's first flit is granted, the input is locked until its last flit transfers, so packets never interleave.
- Used as the merge point in ring routers (local injection vs. ring traffic) and in multi-source debug module fan-in.
- Output is registered: one pipeline stage with full throughput.

Parameters:
- N, 2, number of input channels (legal range 2..16).
- WIDTH, 16, flit data width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_data  input  N*WIDTH  flit data; input i occupies bits [i*WIDTH +: WIDTH]
- in_last  input  N  last flit of packet, per input
- in_valid  input  N  flit valid, per input
- in_ready  output  N  flit accepted, per input
- out_data  output  WIDTH  registered flit data
- out_last  output  1  registered last flag
- out_valid  output  1  registered valid
- out_ready  input  1  downstream ready
- grant  output  N  one-hot currently selected input; all-zero when none is selected
- busy  output  1  locked OR out_valid

Behaviour:
- State:
  - ptr (round-robin pointer, clog2(N) bits).
  - locked (1 bit).
  - lock_idx (clog2(N) bits).
  - Output register: out_data, out_last, out_valid.
- Reset values: ptr=0, locked=0, lock_idx=0, out_valid=0, out_data=0, out_last=0.
  - in_ready=0 and grant=0 are forced for the cycle rst is high.
- can_accept = !out_valid | out_ready.
- Selection (combinational, same cycle):
  - Locked: sel = lock_idx. grant is one-hot at lock_idx, regardless of in_valid[lock_idx].
  - Unlocked: sel = first i with in_valid[i], searching ptr, ptr+1, ... wrapping mod N. If no input is valid, grant=0.
- in_ready[sel] = can_accept when a selection exists. All other in_ready bits are 0.
- Transfer: xfer = in_valid[sel] & in_ready[sel].
  - On xfer: out_data <= in_data[sel], out_last <= in_last[sel], out_valid <= 1.
  - Otherwise, if out_ready: out_valid <= 0. out_data and out_last hold.
- Lock FSM: IDLE (locked=0) and LOCKED (locked=1).
  - IDLE, xfer with in_last=0: go to LOCKED, lock_idx <= sel.
  - IDLE, xfer with in_last=1 (single-flit packet): stay IDLE, ptr <= sel+1 mod N.
  - LOCKED, xfer with in_last=1: go to IDLE, ptr <= lock_idx+1 mod N.
  - LOCKED, any other cycle: hold.
- Locked input drops in_valid mid-packet: the lock holds. No other input is served; the output bubbles.
- Latency: input flit to out_valid is 1 cycle. Throughput is 1 flit/cycle while out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 gives in_ready=0 for all inputs. Output data holds stable.
- Packet boundary: the next packet may be granted in the cycle after its predecessor's last flit. No dead cycle.
- Fairness: after a packet completes from input k, input k has the lowest priority at the next arbitration.
- Reset mid-packet: the lock is released, ptr returns to 0 and any flit in the output register is discarded.
- Pointer wrap: N-1 incremented by one gives 0. For non-power-of-2 N, ptr never holds a value >= N.
- Simultaneous valid on all inputs: exactly one grant; the others see in_ready=0.
- No combinational path from out_ready to out_valid or out_data.

Test Plan:
1. Single source. N=2, input0 sends a 3-flit packet 0x0001, 0x0002, 0x0003 (last), out_ready=1 -> the same flits appear on out_data at cycles t+1..t+3, out_last set only with 0x0003, then ptr=1.
2. Contention. Both inputs present 2-flit packets in the same cycle, ptr=0 -> input0's packet is emitted first, contiguously, then input1's with no gap. in_ready[1]=0 while input0 is locked.
3. Round-robin. N=4, all inputs continuously present single-flit packets -> grant order 0,1,2,3,0,... and each packet's value appears exactly once.
4. Backpressure. out_ready=0 for 5 cycles mid-packet -> out_data holds, all in_ready=0, no flit lost or duplicated. Transfer resumes on the first cycle out_ready=1.
5. Bubble in worm. Input0 drops valid for 2 cycles between flits while input1 is valid -> input1 is not granted until input0's last flit transfers.
6. Reset mid-packet. rst asserted after the 1st of 4 flits -> out_valid=0 and busy=0 the next cycle. A fresh packet on input1 is then granted; ptr restarts at 0.
